slave_mem_stream_reader: RTL
============================

// Module: slave_mem_stream_reader
// PURPOSE
// - Port-2 (s2) master of the shared 256x8 dual-port mailbox RAM; the Nios II writes jobs through port 1.
// - Polls a doorbell byte, reads LEN payload bytes and streams them out on a valid/ready byte interface
//   (feeds the GreenPAK programming shifter), then writes a status byte back for the CPU.
// PARAMETERS
// - CMD_ADDR   8'h00  doorbell/command byte; nonzero = job pending
// - LEN_ADDR   8'h01  payload length byte, legal range 1..BUF_SIZE
// - STAT_ADDR  8'h02  status byte written back at end of job
// - BUF_BASE   8'h10  first payload address; BUF_SIZE = 256-BUF_BASE (240)
// - POLL_GAP   16     idle cycles between doorbell polls (>=1)
// PORTS
// - clk            in   1  system clock; single clock domain
// - reset_n        in   1  asynchronous reset, active low
// - enable         in   1  1 = polling allowed; sampled only in IDLE
// - abort          in   1  level; terminates current job (see below)
// - mem_address    out  8  to RAM address2
// - mem_chipselect out  1  to RAM chipselect2
// - mem_write      out  1  to RAM write2
// - mem_writedata  out  8  to RAM writedata2
// - mem_clken      out  1  to RAM clken2; constant 1 after reset
// - mem_readdata   in   8  from RAM readdata2
// - m_data         out  8  stream byte
// - m_valid        out  1  stream byte valid
// - m_ready        in   1  downstream accepts when m_valid&m_ready
// - m_last         out  1  qualifies final byte of job
// - cmd_code       out  8  command byte latched at job start
// - busy           out  1  1 in any state other than IDLE
// - done_pulse     out  1  one-cycle pulse in the cycle the status write is issued
// BEHAVIOUR
// - Reset: all outputs 0 except mem_clken=1; state=IDLE, poll counter=0, cmd_code=0.
// - RAM read timing: address/chipselect issued in cycle N (write=0); mem_readdata valid and sampled in N+1.
// - Writes: chipselect=1, write=1 for exactly one cycle; chipselect/write are 0 whenever no access is made.
// - IDLE: if enable, count POLL_GAP cycles, then -> RD_CMD. enable=0 holds counter at 0.
// - RD_CMD: issue read CMD_ADDR -> CMD_W: sample; 0 -> IDLE; else latch cmd_code -> RD_LEN.
// - RD_LEN: issue read LEN_ADDR -> LEN_W: sample LEN; LEN==0 or LEN>BUF_SIZE -> WR_STAT with 8'h81;
//   else idx=0 -> RD_DAT.
// - RD_DAT: issue read BUF_BASE+idx -> DAT_W: load m_data, m_valid=1, m_last=(idx==LEN-1) -> HOLD.
// - HOLD: m_data/m_last stable while m_valid&!m_ready; on handshake m_valid=0 same edge;
//   last -> WR_STAT with 8'h01, else idx+1 -> RD_DAT. Throughput: 1 byte per 3 cycles with m_ready=1.
// - WR_STAT: write status to STAT_ADDR, done_pulse=1 -> CLR_CMD: write 8'h00 to CMD_ADDR -> IDLE.
// - Address arithmetic is 8-bit; BUF_BASE+idx never wraps because LEN<=BUF_SIZE is enforced.
// - abort=1 in RD_CMD..HOLD: drop m_valid (byte not delivered), -> WR_STAT with 8'h82; ignored in
//   WR_STAT/CLR_CMD (job completes status write). abort in IDLE: no effect.
// - CPU writing CMD/LEN mid-job: no effect; values are latched once per job.
// - Port-1/port-2 same-address collisions: CPU must not touch the mailbox while busy; no arbitration here.
// - reset_n asserted mid-job: immediate return to reset state; no status written, doorbell left set.
// TESTING
// - CMD=8'h5A, LEN=3, buf=11,22,33, m_ready=1 -> bytes 11,22,33, m_last on 33, STAT=01, CMD=00, cmd_code=5A.
// - Same job, m_ready low 5 cycles on byte 2 -> m_data=22 held stable, no extra RAM reads, order intact.
// - LEN=0 and LEN=241 -> no m_valid, STAT=81, CMD cleared, one done_pulse each.
// - LEN=240 -> last read address 8'hFF, 240 bytes, m_last only on final byte, no wrap to 8'h00.
// - abort during byte 2 HOLD of LEN=4 -> m_valid drops, STAT=82, CMD=00, returns IDLE.
// - CMD=0 with enable=1 -> polls every POLL_GAP+2 cycles, no writes; reset_n low mid-stream -> outputs 0.

Source files
------------

// File: rtl/slave_mem_stream_reader_if.sv
// Mailbox RAM port-2 bus plus outgoing byte stream.
// The reader is master of both.
interface slave_mem_stream_reader_if;
    logic [7:0] mem_address;
    logic       mem_chipselect;
    logic       mem_write;
    logic [7:0] mem_writedata;
    logic       mem_clken;
    logic [7:0] mem_readdata;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        output mem_address, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata,
        output m_data, m_valid, m_last,
        input  m_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata,
        input  m_data, m_valid, m_last,
        output m_ready
    );
endinterface

// File: rtl/slave_mem_stream_reader.sv
// Mailbox port-2 job reader: polls doorbell, streams payload,
// writes status and clears the doorbell.
module slave_mem_stream_reader #(
    parameter logic [7:0] CMD_ADDR  = 8'h00,
    parameter logic [7:0] LEN_ADDR  = 8'h01,
    parameter logic [7:0] STAT_ADDR = 8'h02,
    parameter logic [7:0] BUF_BASE  = 8'h10,
    parameter int         POLL_GAP  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            abort,
    slave_mem_stream_reader_if.master       bus,
    output logic [7:0]                      cmd_code,
    output logic                            busy,
    output logic                            done_pulse
);

    localparam logic [7:0] BUF_SIZE = 8'(9'd256 - {1'b0, BUF_BASE});
    localparam int         PW       = $clog2(POLL_GAP + 1);

    localparam logic [7:0] ST_OK    = 8'h01;
    localparam logic [7:0] ST_BADL  = 8'h81;
    localparam logic [7:0] ST_ABORT = 8'h82;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] RD_CMD  = 4'd1;
    localparam logic [3:0] CMD_W   = 4'd2;
    localparam logic [3:0] RD_LEN  = 4'd3;
    localparam logic [3:0] LEN_W   = 4'd4;
    localparam logic [3:0] RD_DAT  = 4'd5;
    localparam logic [3:0] DAT_W   = 4'd6;
    localparam logic [3:0] HOLD    = 4'd7;
    localparam logic [3:0] WR_STAT = 4'd8;
    localparam logic [3:0] CLR_CMD = 4'd9;

    logic [3:0]    state;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    len_q;
    logic [7:0]    idx;
    logic [7:0]    stat_q;
    logic [7:0]    data_q;
    logic          last_q;
    logic          in_job;

    assign in_job = (state >= RD_CMD) && (state <= HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            poll_cnt <= '0;
            cmd_code <= 8'h00;
            len_q    <= 8'h00;
            idx      <= 8'h00;
            stat_q   <= 8'h00;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
        end else if (abort && in_job) begin
            // The byte in HOLD is dropped, not delivered.
            state  <= WR_STAT;
            stat_q <= ST_ABORT;
        end else begin
            case (state)
                IDLE: begin
                    if (!enable) begin
                        poll_cnt <= '0;
                    end else if (poll_cnt == PW'(POLL_GAP - 1)) begin
                        poll_cnt <= '0;
                        state    <= RD_CMD;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                RD_CMD: state <= CMD_W;
                CMD_W: begin
                    if (bus.mem_readdata == 8'h00) begin
                        state <= IDLE;
                    end else begin
                        cmd_code <= bus.mem_readdata;
                        state    <= RD_LEN;
                    end
                end
                RD_LEN: state <= LEN_W;
                LEN_W: begin
                    if (bus.mem_readdata == 8'h00 ||
                        bus.mem_readdata > BUF_SIZE) begin
                        stat_q <= ST_BADL;
                        state  <= WR_STAT;
                    end else begin
                        len_q <= bus.mem_readdata;
                        idx   <= 8'h00;
                        state <= RD_DAT;
                    end
                end
                RD_DAT: state <= DAT_W;
                DAT_W: begin
                    data_q <= bus.mem_readdata;
                    last_q <= (idx == len_q - 8'd1);
                    state  <= HOLD;
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        if (last_q) begin
                            stat_q <= ST_OK;
                            state  <= WR_STAT;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= RD_DAT;
                        end
                    end
                end
                WR_STAT: state <= CLR_CMD;
                CLR_CMD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_address    = 8'h00;
        bus.mem_chipselect = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_writedata  = 8'h00;
        case (state)
            RD_CMD: begin
                bus.mem_address    = CMD_ADDR;
                bus.mem_chipselect = 1'b1;
            end
            RD_LEN: begin
                bus.mem_address    = LEN_ADDR;
                bus.mem_chipselect = 1'b1;
            end
            RD_DAT: begin
                bus.mem_address    = BUF_BASE + idx;
                bus.mem_chipselect = 1'b1;
            end
            WR_STAT: begin
                bus.mem_address    = STAT_ADDR;
                bus.mem_chipselect = 1'b1;
                bus.mem_write      = 1'b1;
                bus.mem_writedata  = stat_q;
            end
            CLR_CMD: begin
                bus.mem_address    = CMD_ADDR;
                bus.mem_chipselect = 1'b1;
                bus.mem_write      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_clken = 1'b1;
    assign bus.m_data    = data_q;
    assign bus.m_valid   = (state == HOLD);
    assign bus.m_last    = (state == HOLD) && last_q;
    assign busy          = (state != IDLE);
    assign done_pulse    = (state == WR_STAT);

endmodule
